// File: rtl/vc_flit_buffer.sv
// Multi-VC input flit buffer: NUM_VC independent circular FIFOs with a registered read port.
// Define VC_FLIT_BUFFER_PROTO_CHECK_EN to enable per-VC packet-framing checks and proto_err.
module vc_flit_buffer #(
    parameter int  FLIT_WIDTH  = 64,
    parameter int  BUFFER_SIZE = 16,
    parameter int  NUM_VC      = 2,
    localparam int VC_W        = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CNT_W       = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FLIT_WIDTH-1:0]   flit_in,
    input  logic                    push,
    input  logic [VC_W-1:0]         push_vc,
    input  logic                    pop,
    input  logic [VC_W-1:0]         pop_vc,
    output logic [FLIT_WIDTH-1:0]   flit_o,
    output logic                    flit_valid,
    output logic [NUM_VC-1:0]       full,
    output logic [NUM_VC-1:0]       empty,
    output logic [NUM_VC*CNT_W-1:0] count,
    output logic                    buffer_on,
    output logic [NUM_VC-1:0]       proto_err
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);

    logic [FLIT_WIDTH-1:0] mem_q    [NUM_VC][BUFFER_SIZE];
    logic [PTR_W-1:0]      wr_ptr_q [NUM_VC];
    logic [PTR_W-1:0]      rd_ptr_q [NUM_VC];
    logic [CNT_W-1:0]      cnt_q    [NUM_VC];
    logic [FLIT_WIDTH-1:0] flit_q;
    logic                  valid_q;

    logic                  push_vc_ok, pop_vc_ok;
    logic                  pop_ok, push_space, push_ok, proto_bad;
    logic [NUM_VC-1:0]     push_hit, pop_hit;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUFFER_SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        full  = '0;
        empty = '0;
        count = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            full[v]                  = (cnt_q[v] == CNT_W'(BUFFER_SIZE));
            empty[v]                 = (cnt_q[v] == '0);
            count[v*CNT_W +: CNT_W]  = cnt_q[v];
        end
    end

    assign buffer_on  = |(~empty);
    assign push_vc_ok = (int'(push_vc) < NUM_VC);
    assign pop_vc_ok  = (int'(pop_vc) < NUM_VC);
    assign pop_ok     = pop && pop_vc_ok && !empty[pop_vc];
    // A full VC still accepts a push when its head leaves in the same cycle.
    assign push_space = push && push_vc_ok &&
                        (!full[push_vc] || (pop_ok && (pop_vc == push_vc)));
    assign push_ok    = push_space && !proto_bad;

    always_comb begin
        push_hit = '0;
        pop_hit  = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            push_hit[v] = push_ok && (push_vc == VC_W'(v));
            pop_hit[v]  = pop_ok  && (pop_vc  == VC_W'(v));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
            end
            flit_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= pop_ok;
            if (pop_ok) flit_q <= mem_q[pop_vc][rd_ptr_q[pop_vc]];
            for (int v = 0; v < NUM_VC; v++) begin
                if (push_hit[v]) wr_ptr_q[v] <= ptr_inc(wr_ptr_q[v]);
                if (pop_hit[v])  rd_ptr_q[v] <= ptr_inc(rd_ptr_q[v]);
                cnt_q[v] <= cnt_q[v] + CNT_W'(push_hit[v]) - CNT_W'(pop_hit[v]);
            end
        end
    end

    // NOTE: storage is deliberately not reset; occupancy is tracked by the pointers and counts alone.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[push_vc][wr_ptr_q[push_vc]] <= flit_in;
    end

    assign flit_o     = flit_q;
    assign flit_valid = valid_q;

`ifdef VC_FLIT_BUFFER_PROTO_CHECK_EN
    typedef enum logic [1:0] {
        FT_HEAD      = 2'b00,
        FT_BODY      = 2'b01,
        FT_TAIL      = 2'b10,
        FT_HEAD_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic {PKT_IDLE, PKT_ACTIVE} pkt_state_e;

    pkt_state_e        pkt_q [NUM_VC];
    pkt_state_e        pkt_d [NUM_VC];
    logic [NUM_VC-1:0] err_q, err_d;
    flit_type_e        ftype;

    assign ftype = flit_type_e'(flit_in[FLIT_WIDTH-1 -: 2]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < NUM_VC; v++) pkt_q[v] <= PKT_IDLE;
            err_q <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) pkt_q[v] <= pkt_d[v];
            err_q <= err_d;
        end
    end

    always_comb begin
        err_d = err_q;
        for (int v = 0; v < NUM_VC; v++) begin
            pkt_d[v] = pkt_q[v];
            if (push_space && (push_vc == VC_W'(v))) begin
                if (proto_bad)                err_d[v] = 1'b1;
                else if (ftype == FT_HEAD)    pkt_d[v] = PKT_ACTIVE;
                else if (ftype != FT_BODY)    pkt_d[v] = PKT_IDLE;
            end
        end
    end

    always_comb begin
        proto_bad = 1'b0;
        if (push_vc_ok) begin
            if (pkt_q[push_vc] == PKT_IDLE)
                proto_bad = (ftype == FT_BODY) || (ftype == FT_TAIL);
            else
                proto_bad = (ftype == FT_HEAD) || (ftype == FT_HEAD_TAIL);
        end
    end

    assign proto_err = err_q;
`else
    assign proto_bad = 1'b0;
    assign proto_err = '0;
`endif

endmodule
